mont_mul_cios: RTL

- Word-serial Montgomery multiplier, CIOS method; computes result = a·b·R⁻¹ mod n with R = 2^NBITS.
- Sits directly downstream of the modular-inverse stage and consumes its 64-bit n' = −n⁻¹ mod 2^W output on n_prime.
- Uses one W×W multiplier and an (S+2)-word accumulator T, where S = NBITS/W.
- The RSA exponentiation controller uses it as the core modmul engine.

---
 rtl/mont_mul_cios.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mont_mul_cios.sv
// Word-serial CIOS Montgomery multiplier: result = a*b*2^-NBITS mod n, one WxW multiplier.
// Define MONT_FINAL_SUB_EN to add the final conditional subtraction (result < n); otherwise result is in [0, 2n).
module mont_mul_cios #(
  parameter int NBITS = 4096,
  parameter int W     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] n,
  input  logic [W-1:0]     n_prime,
  output logic [NBITS:0]   result,
  output logic             valid,
  output logic             busy
);
  localparam int S  = NBITS / W;
  localparam int CW = $clog2(S + 1);
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  // state | meaning
  // IDLE/DONE idle, go accepted | MUL a*b[i] row | MTOP fold carry | MCALC m=T0*n'
  // RED m*n row, shift one word | RTOP fold top, next i | SUB T-n | FIN load result
  typedef enum logic [3:0] {IDLE, MUL, MTOP, MCALC, RED, RTOP, SUB, FIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [NBITS-1:0]   a_r, b_r, n_r;
  logic [(S+2)*W-1:0] t_r;
  logic [W-1:0]       np_r, m_r, c_r;
  logic [CW-1:0]      i_r, j_r;
  logic [W-1:0]       mul_x, mul_y, t_j, t_s, t_s1;
  logic [2*W-1:0]     prod, sum;
  logic [W:0]         top_sum;
  logic               last_j, last_i;

`ifdef MONT_FINAL_SUB_EN
  logic [NBITS-1:0]   d_r;
  logic               brw_r;
  logic [W:0]         diff;
  assign diff = {1'b0, t_j} - {1'b0, n_r[j_r*W +: W]} - {{W{1'b0}}, brw_r};
`endif

  assign last_j  = (j_r == LAST);
  assign last_i  = (i_r == LAST);
  assign t_j     = t_r[j_r*W +: W];
  assign t_s     = t_r[S*W +: W];
  assign t_s1    = t_r[(S+1)*W +: W];
  assign prod    = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};
  assign sum     = {{W{1'b0}}, t_j} + prod + {{W{1'b0}}, c_r};
  assign top_sum = {1'b0, t_s} + {1'b0, c_r};
  assign busy    = (state != IDLE) && (state != DONE);

  // The single multiplier is shared by the MUL row, the m computation and the RED row
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state)
      MUL:   begin mul_x = a_r[j_r*W +: W]; mul_y = b_r[i_r*W +: W]; end
      MCALC: begin mul_x = t_r[W-1:0];      mul_y = np_r;            end
      RED:   begin mul_x = m_r;             mul_y = n_r[j_r*W +: W]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (go) state_nxt = MUL;
      MUL:        if (last_j) state_nxt = MTOP;
      MTOP:       state_nxt = MCALC;
      MCALC:      state_nxt = RED;
      RED:        if (last_j) state_nxt = RTOP;
`ifdef MONT_FINAL_SUB_EN
      RTOP:       state_nxt = last_i ? SUB : MUL;
`else
      RTOP:       state_nxt = last_i ? FIN : MUL;
`endif
      SUB:        if (last_j) state_nxt = FIN;
      FIN:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      n_r    <= '0;
      np_r   <= '0;
      t_r    <= '0;
      m_r    <= '0;
      c_r    <= '0;
      i_r    <= '0;
      j_r    <= '0;
      result <= '0;
      valid  <= 1'b0;
`ifdef MONT_FINAL_SUB_EN
      d_r    <= '0;
      brw_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (go) begin
          a_r   <= a;
          b_r   <= b;
          n_r   <= n;
          np_r  <= n_prime;
          t_r   <= '0;
          c_r   <= '0;
          i_r   <= '0;
          j_r   <= '0;
          valid <= 1'b0;
        end
        MUL: begin
          t_r[j_r*W +: W] <= sum[W-1:0];
          c_r             <= sum[2*W-1:W];
          j_r             <= last_j ? '0 : j_r + 1'b1;
        end
        MTOP: begin
          t_r[S*W +: 2*W] <= {{W{1'b0}}, t_s} + {{W{1'b0}}, c_r};
          c_r             <= '0;
        end
        MCALC: m_r <= prod[W-1:0];
        RED: begin
          // j=0 only produces the carry: the low word is zero by construction of m
          if (j_r != '0) t_r[(j_r - 1'b1)*W +: W] <= sum[W-1:0];
          c_r <= sum[2*W-1:W];
          j_r <= last_j ? '0 : j_r + 1'b1;
        end
        RTOP: begin
          t_r[(S-1)*W +: W] <= top_sum[W-1:0];
          t_r[S*W +: W]     <= t_s1 + {{(W-1){1'b0}}, top_sum[W]};
          t_r[(S+1)*W +: W] <= '0;
          c_r               <= '0;
          i_r               <= i_r + 1'b1;
`ifdef MONT_FINAL_SUB_EN
          brw_r             <= 1'b0;
`endif
        end
`ifdef MONT_FINAL_SUB_EN
        SUB: begin
          d_r[j_r*W +: W] <= diff[W-1:0];
          brw_r           <= diff[W];
          j_r             <= last_j ? '0 : j_r + 1'b1;
        end
`endif
        FIN: begin
`ifdef MONT_FINAL_SUB_EN
          result <= (t_s[0] || !brw_r) ? {1'b0, d_r} : {1'b0, t_r[NBITS-1:0]};
`else
          result <= t_r[NBITS:0];
`endif
          valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
